// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vectors,
// sequencer state encodings and the multi-cycle aluop codes.
package pipe_pkg;

    // Stall vector bit order: {wb, mem, ex, id, if, pc}
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    // Stall applied whenever the sequencer is not holding EX.
    function automatic logic [5:0] idle_stall(input logic id_req);
        return id_req ? STALL_ID : STALL_NONE;
    endfunction

    function automatic logic is_mc_op(input logic [7:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges the ID load-use stall with the
// sequencer for the iterative div/mul unit and counts stalled cycles.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             mc_req_i,
    input  logic [7:0]       mc_op_i,
    input  logic             mc_done_i,
    input  logic [63:0]      mc_result_i,
    input  logic             flush_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             mc_start_o,
    output logic [7:0]       mc_op_o,
    output logic             mc_cancel_o,
    output logic             mc_ready_o,
    output logic [63:0]      mc_result_o,
    output logic             mc_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_dbg
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e     state;
    logic [7:0] wait_cnt;

    assign state_dbg = state;

    // Handshake with the iterative unit: mc_start_o is a single-cycle pulse
    // carrying mc_op_o; the unit answers with a single-cycle mc_done_i, which is
    // honoured only in WAIT. mc_cancel_o aborts an op in flight. Towards EX,
    // mc_ready_o is a single-cycle valid for mc_result_o/mc_err_o and EX is
    // released in that same cycle, so no ready/back-pressure is needed.
    always_comb begin
        stall_o = STALL_NONE;
        if (!rst && !flush_i) begin
            case (state)
                ST_IDLE:  stall_o = mc_req_i ? STALL_EX : idle_stall(stallreq_id_i);
                ST_START: stall_o = STALL_EX;
                ST_WAIT:  stall_o = STALL_EX;
                ST_DONE:  stall_o = idle_stall(stallreq_id_i);
                default:  stall_o = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            flush_o     <= 1'b0;
            mc_start_o  <= 1'b0;
            mc_cancel_o <= 1'b0;
            mc_ready_o  <= 1'b0;
            mc_err_o    <= 1'b0;
            mc_result_o <= '0;
            mc_op_o     <= '0;
        end else begin
            flush_o     <= flush_i;
            mc_start_o  <= 1'b0;
            mc_cancel_o <= 1'b0;
            mc_ready_o  <= 1'b0;
            if (flush_i) begin
                // Only an op the unit is still working on needs an abort.
                if (state == ST_START || state == ST_WAIT) begin
                    mc_cancel_o <= 1'b1;
                end
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (mc_req_i) begin
                            mc_op_o    <= mc_op_i;
                            mc_start_o <= 1'b1;
                            state      <= ST_START;
                        end
                    end
                    ST_START: begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (mc_done_i) begin
                            mc_result_o <= mc_result_i;
                            mc_err_o    <= 1'b0;
                            mc_ready_o  <= 1'b1;
                            state       <= ST_DONE;
                        end else if (wait_cnt == WAIT_LAST) begin
                            mc_result_o <= '0;
                            mc_err_o    <= 1'b1;
                            mc_ready_o  <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // mc_req_i here still belongs to the finishing instruction.
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (stall_o != STALL_NONE),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table plus hand-written
// sequences for reset behaviour and counter saturation.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        mc_req;
    logic [7:0]  mc_op;
    logic        mc_done;
    logic [63:0] mc_result;
    logic        flush;

    logic [5:0]  stall_o;
    logic        flush_o, mc_start_o, mc_cancel_o, mc_ready_o, mc_err_o;
    logic [7:0]  mc_op_o;
    logic [63:0] mc_result_o;
    logic [31:0] stall_cnt_o;
    logic [1:0]  state_dbg;

    logic [5:0]  s_stall;
    logic        s_flush, s_start, s_cancel, s_ready, s_err;
    logic [7:0]  s_op;
    logic [63:0] s_result;
    logic [2:0]  s_cnt;
    logic [1:0]  s_state;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id), .mc_req_i(mc_req),
        .mc_op_i(mc_op), .mc_done_i(mc_done), .mc_result_i(mc_result), .flush_i(flush),
        .stall_o(stall_o), .flush_o(flush_o), .mc_start_o(mc_start_o), .mc_op_o(mc_op_o),
        .mc_cancel_o(mc_cancel_o), .mc_ready_o(mc_ready_o), .mc_result_o(mc_result_o),
        .mc_err_o(mc_err_o), .stall_cnt_o(stall_cnt_o), .state_dbg(state_dbg)
    );

    // Narrow counter copy, used only to observe saturation.
    pipe_ctrl #(.TIMEOUT(64), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id), .mc_req_i(mc_req),
        .mc_op_i(mc_op), .mc_done_i(mc_done), .mc_result_i(mc_result), .flush_i(flush),
        .stall_o(s_stall), .flush_o(s_flush), .mc_start_o(s_start), .mc_op_o(s_op),
        .mc_cancel_o(s_cancel), .mc_ready_o(s_ready), .mc_result_o(s_result),
        .mc_err_o(s_err), .stall_cnt_o(s_cnt), .state_dbg(s_state)
    );

    typedef struct {
        logic        id, req;
        logic [7:0]  op;
        logic        done;
        logic [63:0] res;
        logic        fl;
        logic [5:0]  stall;
        logic        start, ready, cancel, flo;
        logic        push;
        logic [64:0] pv;
        logic        sat;
    } vec_t;

    vec_t        vecs[$];
    logic [64:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cnt;

    localparam logic [63:0] RB = 64'h0000_0003_0000_0002;
    localparam logic [63:0] RD = 64'hDEAD_BEEF_0000_0007;
    localparam logic [5:0]  S0 = STALL_NONE;
    localparam logic [5:0]  SI = STALL_ID;
    localparam logic [5:0]  SE = STALL_EX;

    function automatic vec_t mk(input logic id, req, input logic [7:0] op, input logic done,
                                input logic [63:0] res, input logic fl, input logic [5:0] stall,
                                input logic start, ready, cancel, flo, push,
                                input logic [64:0] pv, input logic sat);
        vec_t v;
        v.id = id; v.req = req; v.op = op; v.done = done; v.res = res; v.fl = fl;
        v.stall = stall; v.start = start; v.ready = ready; v.cancel = cancel; v.flo = flo;
        v.push = push; v.pv = pv; v.sat = sat;
        return v;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, req, input logic [7:0] op, input logic done,
                         input logic [63:0] res, input logic fl);
        stallreq_id = id; mc_req = req; mc_op = op; mc_done = done; mc_result = res; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every mc_ready_o pulse must match the oldest expected {err, result}.
    always @(negedge clk) begin
        if (mc_ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_unexpected: got ready with 0x%0h, expected none", mc_result_o);
            end else begin
                check("ready_payload", {mc_err_o, mc_result_o}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, OP_DIV, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("stall_in_reset", stall_o, S0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rst_stall", stall_o, S0);
        check("rst_outs", {flush_o, mc_start_o, mc_cancel_o, mc_ready_o, mc_err_o}, 5'b0);
        check("rst_result", mc_result_o, 64'h0);
        check("rst_op", mc_op_o, 8'h00);
        check("rst_cnt", stall_cnt_o, 32'h0);
        check("rst_state", state_dbg, ST_IDLE);
        next_cycle();
        exp_cnt = 0;

        //              id   req  op        done res    fl   stall st rd cn fo push pv          sat
        // Load-use only
        vecs.push_back(mk(1, 0, 8'h00,    0, '0,    0, SI, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(1, 0, 8'h00,    0, '0,    0, SI, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           0));
        // Divide; done lands on the last WAIT cycle, so done must beat the timeout
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, SE, 1, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   1, RB,    0, SE, 0, 0, 0, 0, 1, {1'b0, RB},   0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    0, S0, 0, 1, 0, 0, 0, '0,           1));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           1));
        // Timeout after four WAIT cycles, then a stray done in IDLE
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 1, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, SE, 0, 0, 0, 0, 1, {1'b1, 64'h0}, 0));
        vecs.push_back(mk(0, 1, OP_DIVU,  0, '0,    0, S0, 0, 1, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    1, 64'h5, 0, S0, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           0));
        // Load-use held across a whole multiply
        vecs.push_back(mk(1, 1, OP_MULTU, 0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(1, 1, OP_MULTU, 0, '0,    0, SE, 1, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(1, 1, OP_MULTU, 0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(1, 1, OP_MULTU, 1, RD,    0, SE, 0, 0, 0, 0, 1, {1'b0, RD},   0));
        vecs.push_back(mk(1, 1, OP_MULTU, 0, '0,    0, SI, 0, 1, 0, 0, 0, '0,           0));
        vecs.push_back(mk(1, 0, 8'h00,    0, '0,    0, SI, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           0));
        // Flush in WAIT, stray done afterwards, then flush racing a new request
        vecs.push_back(mk(0, 1, OP_MULT,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_MULT,  0, '0,    0, SE, 1, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_MULT,  0, '0,    0, SE, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_MULT,  0, '0,    1, S0, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 1, 1, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    1, 64'h9, 0, S0, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 1, OP_DIV,   0, '0,    1, S0, 0, 0, 0, 0, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 1, 0, '0,           0));
        vecs.push_back(mk(0, 0, 8'h00,    0, '0,    0, S0, 0, 0, 0, 0, 0, '0,           0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.id, v.req, v.op, v.done, v.res, v.fl);
            if (v.push) exp_q.push_back(v.pv);
            @(negedge clk);
            check($sformatf("row%0d_stall", i), stall_o, v.stall);
            check($sformatf("row%0d_start", i), mc_start_o, v.start);
            check($sformatf("row%0d_ready", i), mc_ready_o, v.ready);
            check($sformatf("row%0d_cancel", i), mc_cancel_o, v.cancel);
            check($sformatf("row%0d_flush", i), flush_o, v.flo);
            check($sformatf("row%0d_cnt", i), stall_cnt_o, exp_cnt);
            if (v.start) check($sformatf("row%0d_op", i), mc_op_o, v.op);
            if (v.sat) check($sformatf("row%0d_sat_cnt", i), s_cnt, 3'b111);
            if (v.stall != S0) exp_cnt++;
            next_cycle();
        end

        // Reset while WAITing: silent abandon, then a fresh request is accepted.
        drive(1'b0, 1'b1, OP_DIVU, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rw_accept_stall", stall_o, SE);
        next_cycle();
        @(negedge clk);
        check("rw_start", mc_start_o, 1'b1);
        next_cycle();
        @(negedge clk);
        check("rw_state_wait", state_dbg, ST_WAIT);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rw_stall_in_reset", stall_o, S0);
        next_cycle();
        rst = 1'b0;
        mc_req = 1'b0;
        @(negedge clk);
        check("rw_outs", {flush_o, mc_start_o, mc_cancel_o, mc_ready_o, mc_err_o}, 5'b0);
        check("rw_result", mc_result_o, 64'h0);
        check("rw_op", mc_op_o, 8'h00);
        check("rw_cnt", stall_cnt_o, 32'h0);
        check("rw_sat_cnt", s_cnt, 3'b000);
        check("rw_stall", stall_o, S0);
        next_cycle();
        drive(1'b0, 1'b1, OP_MULT, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rw_new_stall", stall_o, SE);
        check("rw_new_nostart", mc_start_o, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rw_new_start", mc_start_o, 1'b1);
        check("rw_new_op", mc_op_o, OP_MULT);
        check("rw_new_cnt", stall_cnt_o, 32'd1);
        next_cycle();

        check("scoreboard_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
